div_ctrl: RTL and testbench
===========================

// Module: div_ctrl
// PURPOSE
//   Sequencer for the iterative 32-bit integer divider behind the EX stage's div request port.
//   Accepts one div.w/mod.w/div.wu/mod.wu request from EX with a valid/ready handshake.
//   Runs a radix-2 restoring division, one quotient bit per cycle.
//   Returns the selected quotient or remainder through a valid/ready response channel.
// PARAMETERS
//   WIDTH  32  operand/result width; iteration count equals WIDTH
// PORTS
//   clk         in   1      clock, all state on rising edge
//   rst         in   1      asynchronous active-low reset (0 = reset)
//   flush       in   1      cancel in-flight/pending operation (pipeline flush)
//   req_valid   in   1      EX presents a divide request
//   req_ready   out  1      controller accepts request this cycle
//   div_op      in   4      one-hot: [0] div.w, [1] mod.w, [2] div.wu, [3] mod.wu
//   src1        in   WIDTH  dividend
//   src2        in   WIDTH  divisor
//   resp_valid  out  1      result available
//   resp_ready  in   1      consumer takes result this cycle
//   result      out  WIDTH  quotient or remainder per latched div_op
//   busy        out  1      state != IDLE
// BEHAVIOUR
//   - Reset (rst=0, async): state=IDLE, counter=0, result=0, resp_valid=0, busy=0. Reset mid-op discards work.
//   - States: IDLE -> CALC -> DONE -> IDLE.
//   - IDLE: req_ready = ~flush.
//     - Accept on req_valid & req_ready edge t.
//     - Latch: signed = div_op[0]|div_op[1]; want_rem = div_op[1]|div_op[3].
//     - Latch |src1|, |src2| (abs only when signed), quotient sign = s1^s2, remainder sign = s1.
//     - div_op decoded by priority bit0>bit1>bit2>bit3; div_op==0 treated as div.wu.
//   - CALC: req_ready=0.
//     - Each edge: shift partial remainder left one bit, bring in the next dividend MSB, trial-subtract the divisor.
//     - If no borrow: keep difference, quotient bit = 1; else quotient bit = 0.
//     - counter 0..WIDTH-1; after step WIDTH-1 go to DONE.
//     - Steps occur on edges t+1..t+WIDTH; resp_valid=1 from edge t+WIDTH (fixed latency WIDTH, no early exit).
//   - DONE: resp_valid=1; result is sign-corrected, registered, and held stable while resp_ready=0.
//     - resp_valid & resp_ready -> IDLE next edge.
//     - New request not accepted in the same cycle; one bubble cycle.
//   - Sign correction: signed quotient negated if qsign; signed remainder negated if rsign. Arithmetic is modulo 2^WIDTH.
//   - Divide by zero: no trap, same latency. Quotient = all ones (all ops). Remainder = src1 unchanged (all ops).
//   - Signed overflow 0x80000000 div.w 0xFFFFFFFF: quotient 0x80000000, remainder 0.
//   - flush: priority over everything except reset.
//     - Any state -> IDLE next edge; resp_valid=0 next cycle; result keeps its last value.
//     - flush & req_valid in IDLE: no accept (req_ready=0).
//   - resp_valid never asserted while state != DONE; busy = (state != IDLE).
// TESTING
//   1. div.w src1=100 src2=7, resp_ready=1 -> resp_valid exactly 32 cycles after accept, result=14.
//   2. mod.w src1=0xFFFFFFF9 (-7) src2=2 -> result=0xFFFFFFFF (-1).
//      div.w same operands -> result=0xFFFFFFFD (-3).
//   3. div.w 0x80000000 / 0xFFFFFFFF -> 0x80000000.
//      mod.w same -> 0.
//      div.wu 0xFFFFFFFF/2 -> 0x7FFFFFFF.
//   4. Divide by zero.
//      div.wu 0x12345678/0 -> 0xFFFFFFFF.
//      mod.wu 5/0 -> 5.
//      div.w 0xFFFFFFF0/0 -> 0xFFFFFFFF.
//   5. Backpressure.
//      Stimulus: resp_ready=0 for 5 cycles after resp_valid, req_valid held high.
//      Response: result stable, req_ready=0 throughout.
//      After resp_ready=1: IDLE, next request accepted one cycle later.
//   6. Flush and reset mid-operation.
//      flush at CALC step 10 -> busy=0 next cycle, no resp_valid; new req 9/3 div.wu -> 3.
//      rst=0 asserted mid-CALC -> resp_valid=0, result=0 immediately (async).

Source files
------------

// File: rtl/div_ctrl.sv
// div_ctrl -- sequencer for the iterative integer divider behind the EX
// stage's div request port.
//
// One div.w / mod.w / div.wu / mod.wu request is accepted over a valid/ready
// handshake. A radix-2 restoring division then produces one quotient bit per
// cycle for WIDTH cycles, with no early exit. The sign-corrected quotient or
// remainder is presented on a valid/ready response channel.
//
// Ports
//   clk         clock, all state on rising edge
//   rst         asynchronous active-low reset
//   flush       cancel pending/in-flight operation (wins over everything but rst)
//   req_valid   request present
//   req_ready   request accepted this cycle (IDLE and no flush)
//   div_op      one-hot op: [0] div.w [1] mod.w [2] div.wu [3] mod.wu
//   src1, src2  dividend, divisor
//   resp_valid  result available (only in DONE)
//   resp_ready  consumer takes result
//   result      registered quotient/remainder, held until next completion
//   busy        controller not in IDLE
//
// WIDTH must be at least 2.

module div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       div_op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Per-operation context captured at accept time.
  typedef struct packed {
    logic want_rem;  // return remainder instead of quotient
    logic qsign;     // negate quotient at the end
    logic rsign;     // negate remainder at the end
    logic dvz;       // divisor was zero
  } ctx_t;

  state_t           state;
  ctx_t             ctx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;   // dividend bits shift out the top, quotient bits shift in
  logic [WIDTH-1:0] dvs;   // magnitude of divisor
  logic [WIDTH-1:0] rem;   // partial remainder

  // ---------------- request decode ----------------
  logic             op_signed, op_rem;
  logic             s1, s2;
  logic [WIDTH-1:0] abs1, abs2;

  // Lowest set bit wins; an all-zero op falls through to div.wu.
  always_comb begin
    op_signed = 1'b0;
    op_rem    = 1'b0;
    if (div_op[0]) begin
      op_signed = 1'b1;
    end else if (div_op[1]) begin
      op_signed = 1'b1;
      op_rem    = 1'b1;
    end else if (div_op[2]) begin
      op_rem    = 1'b0;
    end else if (div_op[3]) begin
      op_rem    = 1'b1;
    end
  end

  assign s1   = op_signed & src1[WIDTH-1];
  assign s2   = op_signed & src2[WIDTH-1];
  assign abs1 = s1 ? -src1 : src1;
  assign abs2 = s2 ? -src2 : src2;

  // ---------------- one restoring step ----------------
  logic [WIDTH:0]   shifted, diff;
  logic             no_borrow;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;

  // Partial remainder stays below the divisor, so WIDTH+1 bits is enough for
  // the shifted value and the top bit of the difference is the borrow.
  assign shifted   = {rem, dvd[WIDTH-1]};
  assign diff      = shifted - {1'b0, dvs};
  assign no_borrow = ~diff[WIDTH];
  assign rem_nxt   = no_borrow ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_nxt   = {dvd[WIDTH-2:0], no_borrow};

  // ---------------- final sign correction ----------------
  // Evaluated against the last step's outputs so the result is registered
  // on the same edge the FSM enters DONE.
  logic [WIDTH-1:0] q_fix, r_fix, res_nxt;

  always_comb begin
    q_fix = quo_nxt;
    if (ctx.dvz)        q_fix = '1;          // divide by zero: all ones, no sign fixup
    else if (ctx.qsign) q_fix = -quo_nxt;
    // Remainder of a zero divisor is |src1|, re-signed back to src1.
    r_fix   = ctx.rsign ? -rem_nxt : rem_nxt;
    res_nxt = ctx.want_rem ? r_fix : q_fix;
  end

  assign req_ready = (state == IDLE) & ~flush;
  assign busy      = (state != IDLE);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ctx        <= '0;
      cnt        <= '0;
      dvd        <= '0;
      dvs        <= '0;
      rem        <= '0;
      result     <= '0;
      resp_valid <= 1'b0;
    end else if (flush) begin
      // Drop the operation; result keeps its last value.
      state      <= IDLE;
      cnt        <= '0;
      resp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            ctx.want_rem <= op_rem;
            ctx.qsign    <= s1 ^ s2;
            ctx.rsign    <= s1;
            ctx.dvz      <= (src2 == '0);
            dvd          <= abs1;
            dvs          <= abs2;
            rem          <= '0;
            cnt          <= '0;
            state        <= CALC;
          end
        end
        CALC: begin
          rem <= rem_nxt;
          dvd <= quo_nxt;
          if (cnt == LAST) begin
            cnt        <= '0;
            result     <= res_nxt;
            resp_valid <= 1'b1;
            state      <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          // req_ready is low here, so a waiting request sees one bubble.
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: directed cases plus randomized operations, scored by a
// queue of expected responses that an independent monitor drains.

module tb_div_ctrl;

  localparam int W = 32;
  localparam logic [3:0] DIVW = 4'b0001, MODW = 4'b0010, DIVU = 4'b0100, MODU = 4'b1000;

  logic         clk, rst, flush, req_valid, req_ready, resp_valid, resp_ready, busy;
  logic [3:0]   div_op;
  logic [W-1:0] src1, src2, result;

  div_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .div_op(div_op),
    .src1(src1), .src2(src2),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .result(result), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] exp;
    int           acc;
    string        nm;
  } txn_t;

  txn_t q[$];
  int   ntot = 0, npass = 0;
  bit   mon_timed = 0;

  function automatic void chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endfunction

  function automatic void fail_now(input string nm, input string why);
    ntot++;
    $display("FAIL %s: %s", nm, why);
  endfunction

  // Reference: plain SV arithmetic plus the documented corner cases.
  function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int k;
    if (op[0])      k = 0;
    else if (op[1]) k = 1;
    else if (op[2]) k = 2;
    else if (op[3]) k = 3;
    else            k = 2;
    if (b == 0) return (k == 1 || k == 3) ? a : '1;
    if (k < 2) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return (k == 0) ? a : '0;
      return (k == 0) ? 32'($signed(a) / $signed(b)) : 32'($signed(a) % $signed(b));
    end
    return (k == 2) ? a / b : a % b;
  endfunction

  // Monitor: outputs and handshake inputs are stable at the falling edge.
  initial begin
    txn_t d;
    forever begin
      @(negedge clk);
      if (resp_valid) begin
        chk("resp_valid_implies_busy", {31'd0, busy}, 32'd1);
        if (q.size() == 0) begin
          fail_now("spurious_resp", $sformatf("resp_valid=1 result=%h with nothing outstanding", result));
        end else begin
          if (!mon_timed) begin
            chk({q[0].nm, "_latency"}, 32'(cyc - q[0].acc), 32'(W));
            mon_timed = 1;
          end
          chk(q[0].nm, result, q[0].exp);
          if (resp_ready) begin
            d = q.pop_front();
            mon_timed = 0;
          end
        end
      end
    end
  end

  // Drivers act 1 time unit after the rising edge.
  task automatic nstep();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp, input string nm, input bit hold);
    int n = 0;
    txn_t t;
    div_op = op; src1 = a; src2 = b; req_valid = 1'b1;
    #1;
    while (!req_ready && n < 200) begin
      nstep(); #1; n++;
    end
    if (!req_ready) begin
      fail_now({nm, "_accept"}, "request never accepted");
      req_valid = 1'b0;
      return;
    end
    t.exp = exp; t.acc = cyc + 1; t.nm = nm;
    q.push_back(t);
    nstep();
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_done(input bit rnd);
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      resp_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      nstep(); n++;
    end
    if (q.size() != 0) begin
      fail_now("resp_timeout", $sformatf("%0d responses outstanding", q.size()));
      q.delete();
      mon_timed = 0;
    end
  endtask

  task automatic run(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] exp, input string nm);
    issue(op, a, b, exp, nm, 1'b0);
    wait_done(1'b0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'd1;
      2: return '1;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 15));
      default: return 32'($urandom());
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]   op;
    logic [W-1:0] a, b;
    int n;
    txn_t d;
    rst = 1'b0; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
    div_op = '0; src1 = '0; src2 = '0;
    #3;
    chk("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
    nstep(); nstep();
    rst = 1'b1;
    nstep();

    run(DIVW, 32'd100, 32'd7, 32'd14, "divw_100_7");
    run(MODW, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "modw_m7_2");
    run(DIVW, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "divw_m7_2");
    run(DIVW, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "divw_ovf");
    run(MODW, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "modw_ovf");
    run(DIVU, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, "divu_max_2");
    run(DIVU, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, "divu_by0");
    run(MODU, 32'd5, 32'd0, 32'd5, "modu_by0");
    run(DIVW, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFFF, "divw_by0");
    run(MODW, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, "modw_by0");
    run(4'b0000, 32'd20, 32'd3, 32'd6, "op0_as_divu");
    run(4'b0011, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, "divw_priority");

    // Backpressure: response held, a second request waits with req_valid high.
    resp_ready = 1'b0;
    issue(DIVU, 32'd1000, 32'd10, 32'd100, "bp_first", 1'b1);
    div_op = DIVW; src1 = 32'hFFFF_FFCE; src2 = 32'd7;
    n = 0;
    while (!resp_valid && n < 100) begin nstep(); n++; end
    if (!resp_valid) fail_now("bp_resp_wait", "resp_valid never rose");
    for (int i = 0; i < 5; i++) begin
      chk("bp_req_ready_low", {31'd0, req_ready}, 32'd0);
      nstep();
    end
    resp_ready = 1'b1;
    #1;
    chk("bp_req_ready_in_done", {31'd0, req_ready}, 32'd0);
    nstep();
    #1;
    chk("bp_idle_busy", {31'd0, busy}, 32'd0);
    chk("bp_idle_req_ready", {31'd0, req_ready}, 32'd1);
    issue(DIVW, 32'hFFFF_FFCE, 32'd7, 32'hFFFF_FFF9, "bp_second", 1'b0);
    wait_done(1'b0);

    // Flush with a request present while idle: no accept.
    flush = 1'b1; req_valid = 1'b1; div_op = DIVU; src1 = 32'd8; src2 = 32'd2;
    #1;
    chk("flush_idle_req_ready", {31'd0, req_ready}, 32'd0);
    nstep();
    chk("flush_idle_busy", {31'd0, busy}, 32'd0);
    flush = 1'b0; req_valid = 1'b0;
    nstep();

    // Flush mid-CALC at step 10.
    issue(DIVW, 32'd1000, 32'd7, 32'd142, "flush_calc", 1'b0);
    for (int i = 0; i < 10; i++) nstep();
    flush = 1'b1;
    nstep();
    flush = 1'b0;
    chk("flush_calc_busy", {31'd0, busy}, 32'd0);
    chk("flush_calc_resp_valid", {31'd0, resp_valid}, 32'd0);
    d = q.pop_back();
    mon_timed = 0;
    for (int i = 0; i < 40; i++) nstep();   // any resp_valid here is spurious
    run(DIVU, 32'd9, 32'd3, 32'd3, "after_flush_9_3");

    // Flush while holding a result in DONE: result value retained.
    resp_ready = 1'b0;
    issue(DIVU, 32'd50, 32'd5, 32'd10, "flush_done", 1'b0);
    n = 0;
    while (!resp_valid && n < 100) begin nstep(); n++; end
    if (!resp_valid) fail_now("flush_done_wait", "resp_valid never rose");
    flush = 1'b1;
    nstep();
    flush = 1'b0;
    chk("flush_done_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("flush_done_busy", {31'd0, busy}, 32'd0);
    chk("flush_done_result_kept", result, 32'd10);
    if (q.size() != 0) d = q.pop_back();
    mon_timed = 0;
    resp_ready = 1'b1;
    nstep();

    // Randomized operations with random response backpressure.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0: op = DIVW;
        1: op = MODW;
        2: op = DIVU;
        3: op = MODU;
        default: op = 4'b0000;
      endcase
      a = pick();
      b = pick();
      issue(op, a, b, model(op, a, b), $sformatf("rand%0d_op%h_%h_%h", i, op, a, b), 1'b0);
      wait_done(1'b1);
    end
    resp_ready = 1'b1;

    // Asynchronous reset mid-CALC.
    issue(DIVU, 32'd77, 32'd7, 32'd11, "reset_calc", 1'b0);
    for (int i = 0; i < 15; i++) nstep();
    rst = 1'b0;
    #1;
    chk("async_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("async_rst_result", result, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    q.delete();
    mon_timed = 0;
    nstep();
    rst = 1'b1;
    nstep();
    run(MODU, 32'd100, 32'd9, 32'd1, "after_reset_mod");

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
